// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and select encodings for the multi-cycle control unit
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [1:0] {PC_PLUS4, PC_IMM, PC_ALIGNED, PC_HOLD} pc_sel_t;
  typedef enum logic [1:0] {RD_RESULT, RD_LOAD, RD_PC4, RD_IMM} rd_data_sel_t;
  typedef enum logic [1:0] {WR_BYTE, WR_HALF, WR_WORD} wr_data_sel_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef struct packed {
    logic         imem_req;
    logic         dmem_req;
    logic         dmem_we;
    logic         rf_wr_en;
    logic         src_1_sel;
    logic         src_2_sel;
    logic         addr_align;
    logic         dst_addr_sel;
    pc_sel_t      pc_sel;
    rd_data_sel_t rd_data_sel;
    wr_data_sel_t wr_data_sel;
    imm_sel_t     imm_sel;
    logic [2:0]   ld_ctrl;
    logic [4:0]   s_ctrl;
    logic [3:0]   alu_ctrl;
    logic         pc_en;
  } ctrl_sig_t;

  function automatic logic opcode_legal(input logic [6:0] opcode);
    return opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                          OPC_LOAD, OPC_STORE, OPC_IMM, OPC_OP};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational map from (state, ir, b_flag, address bits) to datapath selects
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit TRAP_ON_MISALIGN = 1'b1
) (
  input  state_t      state,
  input  logic [31:0] ir,
  input  logic        b_flag,
  input  logic [1:0]  result_lo,
  input  logic        dmem_ready,
  output ctrl_sig_t   sig,
  output logic        op_legal,
  output logic        is_mem,
  output logic        is_load,
  output logic        is_branch,
  output logic        misalign
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_store;
  logic       bad_align;
  imm_sel_t   imm;
  logic [3:0] alu;
  logic       src_1;
  logic       src_2;
  logic [4:0] shamt;
  logic       unused_ir_bits;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign rd        = ir[11:7];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_mem    = is_load | is_store;
  assign op_legal  = opcode_legal(opcode);
  assign unused_ir_bits = ^{ir[31], ir[29:25], ir[19:15]};

  // funct3[1:0] gives the access size for both loads and stores
  assign bad_align = ((funct3[1:0] == 2'b01) && result_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (result_lo != 2'b00));
  assign misalign  = TRAP_ON_MISALIGN && is_mem && bad_align;

  always_comb begin
    imm   = IMM_I;
    alu   = ALU_ADD;
    src_1 = 1'b0;
    src_2 = 1'b1;
    shamt = 5'd0;
    case (opcode)
      OPC_OP: begin
        alu   = {ir[30], funct3};
        src_2 = 1'b0;
      end
      OPC_IMM: begin
        alu = {(funct3 == 3'b101) && ir[30], funct3};
        if (funct3[1:0] == 2'b01) shamt = ir[24:20];
      end
      OPC_BRANCH: begin
        alu   = {1'b1, funct3};
        src_2 = 1'b0;
        imm   = IMM_B;
      end
      OPC_STORE: imm = IMM_S;
      OPC_LUI:   imm = IMM_U;
      OPC_AUIPC: begin
        imm   = IMM_U;
        src_1 = 1'b1;
      end
      OPC_JAL: begin
        imm   = IMM_J;
        src_1 = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU operands stay driven through MEM and WB so result holds the address/target
  always_comb begin
    sig        = '0;
    sig.pc_sel = PC_HOLD;
    case (state)
      FETCH:  sig.imem_req = 1'b1;
      DECODE: sig.imm_sel  = imm;
      EXEC, MEM, WB: begin
        sig.imm_sel   = imm;
        sig.alu_ctrl  = alu;
        sig.src_1_sel = src_1;
        sig.src_2_sel = src_2;
        sig.s_ctrl    = shamt;
        if (state == EXEC && is_branch) begin
          sig.pc_en  = 1'b1;
          sig.pc_sel = b_flag ? PC_IMM : PC_PLUS4;
        end
        if (state == MEM) begin
          sig.dst_addr_sel = 1'b1;
          sig.dmem_req     = ~misalign;
          sig.dmem_we      = is_store;
          sig.wr_data_sel  = wr_data_sel_t'(funct3[1:0]);
          sig.ld_ctrl      = funct3;
          if (!misalign && dmem_ready && is_store) begin
            sig.pc_en  = 1'b1;
            sig.pc_sel = PC_PLUS4;
          end
        end
        if (state == WB) begin
          sig.pc_en    = 1'b1;
          sig.rf_wr_en = (rd != 5'd0);
          case (opcode)
            OPC_LOAD:          sig.rd_data_sel = RD_LOAD;
            OPC_JAL, OPC_JALR: sig.rd_data_sel = RD_PC4;
            OPC_LUI:           sig.rd_data_sel = RD_IMM;
            default:           sig.rd_data_sel = RD_RESULT;
          endcase
          case (opcode)
            OPC_JAL:  sig.pc_sel = PC_IMM;
            OPC_JALR: begin
              sig.pc_sel     = PC_ALIGNED;
              sig.addr_align = 1'b1;
            end
            default:  sig.pc_sel = PC_PLUS4;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle RV32I control unit: state register, IR, sticky trap
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR         = 32'h0000_0013,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        b_flag,
  input  logic [31:0] result,
  output logic        rf_wr_en,
  output logic        src_1_sel,
  output logic        src_2_sel,
  output logic        addr_align,
  output logic        dst_addr_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  rd_data_sel,
  output logic [1:0]  wr_data_sel,
  output logic [2:0]  imm_sel,
  output logic [2:0]  ld_ctrl,
  output logic [4:0]  s_ctrl,
  output logic [3:0]  alu_ctrl,
  output logic        pc_en,
  output logic [31:0] ir,
  output logic        trap
);

  state_t    state;
  ctrl_sig_t dec_sig;
  ctrl_sig_t sig;
  logic      op_legal;
  logic      is_mem;
  logic      is_load;
  logic      is_branch;
  logic      misalign;
  logic      unused_result_bits;

  assign unused_result_bits = ^result[31:2];

  ctrl_decode #(
    .TRAP_ON_MISALIGN(TRAP_ON_MISALIGN)
  ) u_decode (
    .state     (state),
    .ir        (ir),
    .b_flag    (b_flag),
    .result_lo (result[1:0]),
    .dmem_ready(dmem_ready),
    .sig       (dec_sig),
    .op_legal  (op_legal),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .is_branch (is_branch),
    .misalign  (misalign)
  );

  // Selects are forced idle while rst is held so requests drop immediately
  always_comb begin
    sig = dec_sig;
    if (rst) begin
      sig        = '0;
      sig.pc_sel = PC_HOLD;
    end
  end

  assign imem_req     = sig.imem_req;
  assign dmem_req     = sig.dmem_req;
  assign dmem_we      = sig.dmem_we;
  assign rf_wr_en     = sig.rf_wr_en;
  assign src_1_sel    = sig.src_1_sel;
  assign src_2_sel    = sig.src_2_sel;
  assign addr_align   = sig.addr_align;
  assign dst_addr_sel = sig.dst_addr_sel;
  assign pc_sel       = sig.pc_sel;
  assign rd_data_sel  = sig.rd_data_sel;
  assign wr_data_sel  = sig.wr_data_sel;
  assign imm_sel      = sig.imm_sel;
  assign ld_ctrl      = sig.ld_ctrl;
  assign s_ctrl       = sig.s_ctrl;
  assign alu_ctrl     = sig.alu_ctrl;
  assign pc_en        = sig.pc_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ir    <= RESET_IR;
      trap  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (op_legal) begin
            state <= EXEC;
          end else begin
            state <= TRAP;
            trap  <= 1'b1;
          end
        end
        EXEC: begin
          if (is_branch)   state <= FETCH;
          else if (is_mem) state <= MEM;
          else             state <= WB;
        end
        MEM: begin
          if (misalign) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else if (dmem_ready) begin
            state <= is_load ? WB : FETCH;
          end
        end
        WB:      state <= FETCH;
        TRAP:    trap  <= 1'b1;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed table, corner sequences and random instructions vs a reference model
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        b_flag = 1'b0;
  logic [31:0] result = 32'h0;
  logic        rf_wr_en, src_1_sel, src_2_sel, addr_align, dst_addr_sel, pc_en, trap;
  logic [1:0]  pc_sel, rd_data_sel, wr_data_sel;
  logic [2:0]  imm_sel, ld_ctrl;
  logic [4:0]  s_ctrl;
  logic [3:0]  alu_ctrl;
  logic [31:0] ir;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .b_flag(b_flag), .result(result),
    .rf_wr_en(rf_wr_en), .src_1_sel(src_1_sel), .src_2_sel(src_2_sel),
    .addr_align(addr_align), .dst_addr_sel(dst_addr_sel), .pc_sel(pc_sel),
    .rd_data_sel(rd_data_sel), .wr_data_sel(wr_data_sel), .imm_sel(imm_sel),
    .ld_ctrl(ld_ctrl), .s_ctrl(s_ctrl), .alu_ctrl(alu_ctrl), .pc_en(pc_en),
    .ir(ir), .trap(trap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    bit          bf;
    logic [31:0] res;
    int          iw, dw;
    int          cycles, rf, pc_sel, rd_sel, alu, dreq, trap;
  } vec_t;

  typedef struct {
    int          cycles, rf, pc_en, pc_sel, rd_sel, align, alu, sctrl;
    int          dreq, we, ldc, wrs, imm, trap, dst_bad, timeout;
    int          chk_alu, chk_imm;
    logic [31:0] ir;
  } obs_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b00, imem_req, dmem_req, dmem_we, rf_wr_en, src_1_sel, src_2_sel,
            addr_align, dst_addr_sel, pc_sel, rd_data_sel, wr_data_sel, imm_sel,
            ld_ctrl, s_ctrl, alu_ctrl, pc_en};
  endfunction

  localparam logic [31:0] IDLE_OUTS = 32'h0030_0000;

  task automatic do_reset();
    imem_valid = 1'b0;
    dmem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one instruction through the handshakes; ends at its pc_en pulse or on trap
  task automatic run_instr(input logic [31:0] instr, input bit bf, input logic [31:0] res,
                           input int iw, input int dw, output obs_t o);
    int  icnt = 0, dcnt = 0;
    bit  fetched = 0, prev_fetch = 0, done = 0;
    o = '{default: 0};
    imem_rdata = instr;
    b_flag = bf;
    result = res;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      imem_valid = imem_req && !fetched && (icnt == iw);
      dmem_ready = dmem_req && (dcnt == dw);
      #1;
      o.cycles++;
      if (prev_fetch) o.imm = int'(imm_sel);
      prev_fetch = 0;
      if ((imem_req && dst_addr_sel) || (dmem_req && !dst_addr_sel)) o.dst_bad = 1;
      if (rf_wr_en) o.rf++;
      if (dmem_req) begin
        o.dreq++;
        if (dmem_we) o.we = 1;
        o.ldc = int'(ld_ctrl);
        o.wrs = int'(wr_data_sel);
        if (!dmem_ready) dcnt++;
      end
      if (imem_req) begin
        if (imem_valid) begin
          fetched = 1;
          prev_fetch = 1;
        end else icnt++;
      end
      if (pc_en) begin
        o.pc_en++;
        o.pc_sel = int'(pc_sel);
        o.rd_sel = int'(rd_data_sel);
        o.align  = int'(addr_align);
        o.alu    = int'(alu_ctrl);
        o.sctrl  = int'(s_ctrl);
        done = 1;
      end
      if (trap) begin
        o.trap = 1;
        done = 1;
      end
    end
    imem_valid = 1'b0;
    o.timeout = done ? 0 : 1;
    o.ir = ir;
  endtask

  // Reference: per-instruction outcome from the instruction's class and field values
  function automatic obs_t model(input logic [31:0] instr, input bit bf, input logic [31:0] res,
                                 input int iw, input int dw);
    obs_t e;
    int op = int'(instr[6:0]);
    int f3 = int'(instr[14:12]);
    int rd = int'(instr[11:7]);
    bit ld = (op == 'h03), st = (op == 'h23), br = (op == 'h63);
    bit jal = (op == 'h6F), jalr = (op == 'h67), lui = (op == 'h37);
    bit opr = (op == 'h33), opi = (op == 'h13), aui = (op == 'h17);
    bit legal = ld | st | br | jal | jalr | lui | opr | opi | aui;
    int size = 1 << (f3 % 4);
    bit mis = (ld | st) && ((res % size) != 0);
    e = '{default: 0};
    e.ir = instr;
    if (!legal) begin
      e.cycles = iw + 3;
      e.trap = 1;
      return e;
    end
    e.chk_imm = opr ? 0 : 1;
    e.imm = (st) ? 1 : (br) ? 2 : (lui | aui) ? 3 : (jal) ? 4 : 0;
    if (mis) begin
      e.cycles = iw + 5;
      e.trap = 1;
      return e;
    end
    e.cycles  = br ? iw + 3 : st ? iw + 4 + dw : ld ? iw + 5 + dw : iw + 4;
    e.pc_en   = 1;
    e.rf      = (!st && !br && rd != 0) ? 1 : 0;
    e.pc_sel  = br ? int'(bf) : jal ? 1 : jalr ? 2 : 0;
    e.rd_sel  = ld ? 1 : (jal | jalr) ? 2 : lui ? 3 : 0;
    e.align   = jalr ? 1 : 0;
    e.chk_alu = lui ? 0 : 1;
    if (opr)      e.alu = (instr[30] ? 8 : 0) + f3;
    else if (opi) e.alu = ((instr[30] && f3 == 5) ? 8 : 0) + f3;
    else if (br)  e.alu = 8 + f3;
    e.sctrl = (opi && (f3 == 1 || f3 == 5)) ? int'(instr[24:20]) : 0;
    if (ld | st) begin
      e.dreq = dw + 1;
      e.we   = st ? 1 : 0;
      e.ldc  = f3;
      e.wrs  = f3 % 4;
    end
    return e;
  endfunction

  task automatic compare(input string t, input obs_t o, input obs_t e);
    check({t, ".timeout"}, o.timeout, 0);
    check({t, ".cycles"}, o.cycles, e.cycles);
    check({t, ".rf_wr_en"}, o.rf, e.rf);
    check({t, ".pc_en"}, o.pc_en, e.pc_en);
    check({t, ".pc_sel"}, o.pc_sel, e.pc_sel);
    check({t, ".rd_data_sel"}, o.rd_sel, e.rd_sel);
    check({t, ".addr_align"}, o.align, e.align);
    check({t, ".s_ctrl"}, o.sctrl, e.sctrl);
    check({t, ".dmem_req"}, o.dreq, e.dreq);
    check({t, ".dmem_we"}, o.we, e.we);
    check({t, ".ld_ctrl"}, o.ldc, e.ldc);
    check({t, ".wr_data_sel"}, o.wrs, e.wrs);
    check({t, ".trap"}, o.trap, e.trap);
    check({t, ".ir"}, o.ir, e.ir);
    check({t, ".dst_addr_sel"}, o.dst_bad, 0);
    if (e.chk_alu != 0) check({t, ".alu_ctrl"}, o.alu, e.alu);
    if (e.chk_imm != 0) check({t, ".imm_sel"}, o.imm, e.imm);
  endtask

  vec_t vecs[$];
  obs_t o, e;

  initial begin
    vecs.push_back('{"add",       32'h002081B3, 0, 32'h0,    0, 0, 4, 1, 0, 0,  0, 0, 0});
    vecs.push_back('{"lw_wait2",  32'h0040A283, 0, 32'h100,  0, 2, 7, 1, 0, 1,  0, 3, 0});
    vecs.push_back('{"beq_taken", 32'h00208463, 1, 32'h0,    0, 0, 3, 0, 1, 0,  8, 0, 0});
    vecs.push_back('{"beq_not",   32'h00208463, 0, 32'h0,    0, 0, 3, 0, 0, 0,  8, 0, 0});
    vecs.push_back('{"jalr",      32'h000100E7, 0, 32'h1235, 0, 0, 4, 1, 2, 2,  0, 0, 0});
    vecs.push_back('{"addi_x0",   32'h00000013, 0, 32'h0,    0, 0, 4, 0, 0, 0,  0, 0, 0});
    vecs.push_back('{"lui",       32'h123453B7, 0, 32'h0,    0, 0, 4, 1, 0, 3, -1, 0, 0});
    vecs.push_back('{"sw_wait1",  32'h0020A023, 0, 32'h104,  0, 1, 5, 0, 0, 0,  0, 2, 0});
    vecs.push_back('{"add_iw2",   32'h002081B3, 0, 32'h0,    2, 0, 6, 1, 0, 0,  0, 0, 0});
    vecs.push_back('{"jal",       32'h010000EF, 0, 32'h0,    0, 0, 4, 1, 1, 2,  0, 0, 0});
    vecs.push_back('{"srai",      32'h40325213, 0, 32'h0,    0, 0, 4, 1, 0, 0, 13, 0, 0});
    vecs.push_back('{"sub_iw1",   32'h402081B3, 0, 32'h0,    1, 0, 5, 1, 0, 0,  8, 0, 0});
    vecs.push_back('{"illegal",   32'hFFFFFFFF, 0, 32'h0,    0, 0, 3, 0, 0, 0, -1, 0, 1});
    vecs.push_back('{"sw_misal",  32'h0020A023, 0, 32'h102,  0, 0, 5, 0, 0, 0, -1, 0, 1});

    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset.outputs", all_outs(), IDLE_OUTS);
    check("reset.ir", ir, 32'h0000_0013);
    check("reset.trap", trap, 0);
    rst = 1'b0;
    #1;
    check("reset.fetch_req", imem_req, 1);

    foreach (vecs[i]) begin
      run_instr(vecs[i].instr, vecs[i].bf, vecs[i].res, vecs[i].iw, vecs[i].dw, o);
      check({vecs[i].name, ".timeout"}, o.timeout, 0);
      check({vecs[i].name, ".cycles"}, o.cycles, vecs[i].cycles);
      check({vecs[i].name, ".rf_wr_en"}, o.rf, vecs[i].rf);
      check({vecs[i].name, ".pc_sel"}, o.pc_sel, vecs[i].pc_sel);
      check({vecs[i].name, ".rd_data_sel"}, o.rd_sel, vecs[i].rd_sel);
      check({vecs[i].name, ".dmem_req"}, o.dreq, vecs[i].dreq);
      check({vecs[i].name, ".trap"}, o.trap, vecs[i].trap);
      check({vecs[i].name, ".dst_addr_sel"}, o.dst_bad, 0);
      if (vecs[i].alu >= 0) check({vecs[i].name, ".alu_ctrl"}, o.alu, vecs[i].alu);
      if (vecs[i].trap != 0) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          imem_valid = 1'b1;
          imem_rdata = 32'h002081B3;
          #1;
          check({vecs[i].name, ".trap_sticky"}, trap, 1);
          check({vecs[i].name, ".trap_idle"}, {imem_req, dmem_req, rf_wr_en, pc_en}, 0);
        end
        check({vecs[i].name, ".trap_ir_held"}, ir, vecs[i].instr);
        do_reset();
      end
    end

    // Reset in the middle of a load with dmem_req high, then a late dmem_ready
    do_reset();
    begin
      bit got = 0;
      imem_rdata = 32'h0040A283;
      result = 32'h100;
      b_flag = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        imem_valid = imem_req;
        dmem_ready = 1'b0;
        #1;
        if (dmem_req) got = 1;
      end
      check("midmem.reached", got, 1);
    end
    rst = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hFFFFFFFF;
    #1;
    check("midmem.outputs", all_outs(), IDLE_OUTS);
    check("midmem.ir", ir, 32'h0000_0013);
    @(posedge clk);
    #1;
    check("rst_with_valid.ir", ir, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0;
    imem_valid = 1'b0;
    dmem_ready = 1'b1;
    #1;
    check("post_rst.fetch", {imem_req, dmem_req}, 2'b10);
    @(negedge clk);
    #1;
    check("late_ready.ignored", {imem_req, dmem_req, rf_wr_en, pc_en}, 4'b1000);
    dmem_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [31:0] w = $urandom;
      logic [31:0] res = $urandom;
      bit bf = 1'($urandom_range(0, 1));
      int iw = $urandom_range(0, 2);
      int dw = $urandom_range(0, 2);
      int ld_f3[5] = '{0, 1, 2, 4, 5};
      int br_f3[6] = '{0, 1, 4, 5, 6, 7};
      int bad_op[3] = '{7'h7F, 7'h0F, 7'h73};
      case ($urandom_range(0, 9))
        0: w[6:0] = 7'h33;
        1: begin
          w[6:0] = 7'h13;
          if (w[14:12] == 3'd1) w[31:25] = 7'h00;
          if (w[14:12] == 3'd5) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        2: begin w[6:0] = 7'h03; w[14:12] = 3'(ld_f3[$urandom_range(0, 4)]); end
        3: begin w[6:0] = 7'h23; w[14:12] = 3'($urandom_range(0, 2)); end
        4: begin w[6:0] = 7'h63; w[14:12] = 3'(br_f3[$urandom_range(0, 5)]); end
        5: w[6:0] = 7'h37;
        6: w[6:0] = 7'h17;
        7: w[6:0] = 7'h6F;
        8: w[6:0] = 7'h67;
        default: w[6:0] = 7'(bad_op[$urandom_range(0, 2)]);
      endcase
      if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
      e = model(w, bf, res, iw, dw);
      run_instr(w, bf, res, iw, dw, o);
      compare($sformatf("rand%0d", n), o, e);
      if (e.trap != 0 || o.trap != 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Control-unit end of the control/datapath link for the multi-cycle RV32I core.
- Sequences fetch/decode/execute/memory/writeback. Drives every datapath select and enable, and consumes b_flag and result back from the datapath.
- Flat ports carry the same names as the ctrl_to_data fields. The core top binds them to that interface's ctrl_unit modport.
- Also owns the instruction/data memory request handshakes and the instruction register (IR).

Parameters:
- RESET_IR, 32'h0000_0013, IR value after reset (ADDI x0,x0,0).
- TRAP_ON_MISALIGN, 1, when 1 a misaligned load/store address enters TRAP.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_valid
- imem_valid  in  1  fetch data valid
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request; held until dmem_ready
- dmem_we  out  1  1=store, 0=load; valid with dmem_req
- dmem_ready  in  1  data access complete
- b_flag  in  1  branch compare true
- result  in  32  ALU result
- rf_wr_en  out  1  register-file write strobe
- src_1_sel  out  1  0=rs1, 1=PC
- src_2_sel  out  1  0=rs2, 1=imm
- addr_align  out  1  clear result[0] (JALR)
- dst_addr_sel  out  1  memory address source: 0=PC, 1=result
- pc_sel  out  2  0=PC+4, 1=PC+imm, 2=aligned result, 3=hold
- rd_data_sel  out  2  0=result, 1=load data, 2=PC+4, 3=imm
- wr_data_sel  out  2  store size: 0=byte, 1=half, 2=word
- imm_sel  out  3  0=I, 1=S, 2=B, 3=U, 4=J
- ld_ctrl  out  3  load funct3 (LB/LH/LW/LBU/LHU)
- s_ctrl  out  5  shift amount IR[24:20] for SLLI/SRLI/SRAI, else 0
- alu_ctrl  out  4  ALU operation
- pc_en  out  1  PC write strobe
- ir  out  32  current instruction register
- trap  out  1  sticky; illegal opcode or misalignment

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Async reset:
  - state=FETCH, ir=RESET_IR, trap=0.
  - All outputs 0; pc_sel resets to 3 (hold).
- Default in every state: strobes rf_wr_en, pc_en, imem_req, dmem_req are 0.
- FETCH:
  - imem_req=1, dst_addr_sel=0.
  - On imem_valid: ir<=imem_rdata, go to DECODE. imem_valid outside FETCH is ignored.
- DECODE:
  - Opcode in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} goes to EXEC; anything else goes to TRAP.
  - imm_sel is driven from the opcode in this state.
- EXEC (ALU operands valid):
  - R-type: alu_ctrl={IR[30],funct3}.
  - OP-IMM: alu_ctrl={IR[30] only for SRAI, funct3}.
  - LOAD/STORE/JALR/AUIPC/JAL: alu_ctrl=ADD (4'b0000).
  - BRANCH: alu_ctrl={1'b1,funct3}. Same cycle: pc_en=1, pc_sel = b_flag ? 1 : 0; next state FETCH.
  - LOAD/STORE: next state MEM. All others: next state WB.
- MEM:
  - dmem_req=1, dst_addr_sel=1, dmem_we=STORE, wr_data_sel=funct3[1:0], ld_ctrl=funct3.
  - Misalignment = half with result[0]=1, or word with result[1:0]!=0. If misaligned and TRAP_ON_MISALIGN: go to TRAP, no request issued.
  - On dmem_ready: LOAD goes to WB. STORE pulses pc_en (pc_sel=0) and goes to FETCH.
- WB: rf_wr_en=1 and pc_en=1 for exactly one cycle, unless rd=x0 (then rf_wr_en=0). Next state FETCH.
  - rd_data_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_sel: JAL=1, JALR=2 with addr_align=1, else 0.
- TRAP: trap=1; all strobes 0; remains until rst.
- Latency with zero wait states:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles. LOAD: 5 cycles.
  - Each imem/dmem wait cycle adds 1.
- Reset mid-operation: any outstanding request is abandoned. A dmem_ready arriving after reset release is ignored because the FSM is in FETCH.
- imem_valid and rst asserted together: rst wins and IR is not loaded.

Decomposition:
- Shared package ctrl_pkg holds:
  - state_t enum.
  - Opcode constants.
  - Encoding enums for pc_sel, rd_data_sel, imm_sel, wr_data_sel.
  - ALU_ADD constant.
- One combinational sub-module, ctrl_decode, maps (state, ir, b_flag, result[1:0]) to select signals. The FSM register, IR and trap live in the top.

Test Plan:
- Reset then fetch ADD x3,x1,x2 (0x002081B3), imem_valid on first request:
  - WB on cycle 4 with rf_wr_en=1, rd_data_sel=0, alu_ctrl=4'b0000, pc_en=1, pc_sel=0.
- LW x5,4(x1) with result=0x100 and dmem_ready delayed 2 cycles:
  - dmem_req held 3 cycles with dst_addr_sel=1, dmem_we=0, ld_ctrl=3'b010.
  - Then WB with rd_data_sel=1; total 7 cycles.
- BEQ with b_flag=1, then again with b_flag=0:
  - EXEC pc_en=1 with pc_sel=1, then pc_sel=0.
  - rf_wr_en never asserted; 3 cycles each.
- JALR x1,0(x2):
  - WB has rd_data_sel=2, pc_sel=2, addr_align=1, rf_wr_en=1.
- Illegal opcode 0xFFFFFFFF, and SW with result=0x102:
  - trap=1 and stays set, no dmem_req.
  - Subsequent imem_valid pulses are ignored until rst.
- rst asserted mid-MEM with dmem_req=1:
  - All outputs 0 immediately; ir=0x00000013.
  - After release the FSM is in FETCH with imem_req=1; a late dmem_ready has no effect.
